parking_lot_counter: RTL and testbench
======================================

// Module: parking_lot_counter
// PURPOSE
// - Front end of the parking-lot occupancy path. Decodes two photo-sensor
//   beams at the lot gate into car-enter and car-exit events.
// - Keeps a saturating occupancy count and presents it as big-endian BCD
//   on bcd[7:0]: [7:4] holds tens, [3:0] holds ones.
// - The count feeds the lot's HEX display driver, which renders digits and
//   the FULL/CLEAR text.
// PARAMETERS
// - CAPACITY  25  maximum occupancy. Legal range 1..99; the count saturates here.
// PORTS
// - clk    in   1  system clock; all state updates on its rising edge
// - reset  in   1  synchronous, active-high reset
// - a      in   1  outer beam, 1 = blocked; asynchronous to clk
// - b      in   1  inner beam, 1 = blocked; asynchronous to clk
// - bcd    out  8  occupancy count, big-endian BCD
// - enter  out  1  one-cycle pulse: a complete entry was decoded
// - exit   out  1  one-cycle pulse: a complete exit was decoded
// - full   out  1  high while count == CAPACITY (combinational from count)
// - empty  out  1  high while count == 0 (combinational from count)
// BEHAVIOUR
// - Synchronizer: a and b each pass through a 2-flop synchronizer, giving
//   as and bs. The FSM sees only {as,bs}.
// - Reset values: synchronizer flops 0, state IDLE, count 0 (bcd = 8'h00),
//   enter = 0, exit = 0. Therefore empty = 1 and full = 0.
// - Reset mid-traversal discards the partial sequence; no pulse is produced.
// - FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT_CLR.
//   Input values below are written {as,bs}.
// - IDLE transitions:
//   - 10 -> EN1
//   - 01 -> EX1
//   - 11 -> WAIT_CLR
//   - 00 -> stay in IDLE
// - Entry path, sequence 10 -> 11 -> 01 -> 00:
//   - EN1: 11 -> EN2; 00 -> IDLE (car backed out); 10 -> stay; 01 -> WAIT_CLR.
//   - EN2: 01 -> EN3; 10 -> EN1 (car reversing); 11 -> stay; 00 -> WAIT_CLR.
//   - EN3: 00 -> IDLE and enter <= 1; 11 -> EN2; 01 -> stay; 10 -> WAIT_CLR.
// - Exit path: mirror of the entry path with a and b swapped.
//   EX1/EX2/EX3 follow 01 -> 11 -> 10 -> 00; the EX3 -> IDLE transition
//   sets exit <= 1.
// - WAIT_CLR: stay until 00, then go to IDLE. No pulse is produced.
// - enter and exit:
//   - registered; high for exactly one cycle per completed sequence;
//   - never high together;
//   - 0 in every cycle with no completion.
// - Count update: on the edge after enter (or exit) is high, count
//   increments (or decrements) by 1.
// - Latency: a raw input change takes 2 edges to reach the FSM. The
//   completing transition registers enter/exit. bcd changes 1 edge after
//   the pulse.
// - BCD arithmetic:
//   - increment: ones 9 -> 0 with tens +1;
//   - decrement: ones 0 -> 9 with tens -1;
//   - both nibbles always hold a valid digit (0..9).
// - Saturation:
//   - enter at count == CAPACITY: the pulse still fires; count holds.
//   - exit at count == 0: the pulse still fires; count holds at 0.
//   - No wrap-around in either direction.
// TESTING
// - After reset, drive ab 00,10,11,01,00 (each held 3 clk):
//   enter pulses exactly once for 1 cycle; bcd goes 8'h00 -> 8'h01;
//   empty falls.
// - From 8'h01, drive ab 00,01,11,10,00:
//   exit pulses once; bcd returns to 8'h00; empty = 1.
// - Drive ab 10,11,10,00 (car enters partway, then reverses out):
//   no enter or exit pulse; bcd unchanged.
// - Drive ab 00 -> 11 directly, then 01, then 00:
//   FSM passes through WAIT_CLR; no pulses; bcd unchanged.
// - Drive 9 entries: bcd reads 8'h09. One more entry gives 8'h10
//   (carry). One exit returns 8'h09 (borrow).
// - Drive 26 entries: bcd saturates at 8'h25 with full = 1; the 26th enter
//   still pulses. Then assert reset mid-sequence with ab = 11:
//   bcd = 8'h00, state IDLE, no pulse; on release the FSM sits in WAIT_CLR
//   until ab = 00.

Source files
------------

// File: rtl/parking_lot_if.sv
// Gate-sensor bundle for the parking-lot counter: raw beams in, occupancy
// count, event strobes and FSM state (for observation) out.
//
// Strobe protocol: enter and exit are single-cycle strobes with no
// back-pressure. There is no ready; a consumer must sample every cycle, and
// the two strobes are never high in the same cycle.
interface parking_lot_if;
  logic       a;
  logic       b;
  logic [7:0] bcd;
  logic       enter;
  logic       exit;
  logic       full;
  logic       empty;
  logic [2:0] state;

  modport master (
    output a, b,
    input  bcd, enter, exit, full, empty, state
  );

  modport slave (
    input  a, b,
    output bcd, enter, exit, full, empty, state
  );
endinterface

// File: rtl/parking_lot_counter.sv
// Parking-lot gate decoder: synchronizes the two beam sensors, decodes
// complete car entries/exits with an FSM and keeps a saturating BCD count.
module parking_lot_counter #(
  parameter int CAPACITY = 25
) (
  input logic          clk,
  input logic          reset,
  parking_lot_if.slave bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] EN1      = 3'd1;
  localparam logic [2:0] EN2      = 3'd2;
  localparam logic [2:0] EN3      = 3'd3;
  localparam logic [2:0] EX1      = 3'd4;
  localparam logic [2:0] EX2      = 3'd5;
  localparam logic [2:0] EX3      = 3'd6;
  localparam logic [2:0] WAIT_CLR = 3'd7;

  localparam logic [3:0] CAP_TENS = 4'(CAPACITY / 10);
  localparam logic [3:0] CAP_ONES = 4'(CAPACITY % 10);

  logic       a_meta, a_sync, b_meta, b_sync;
  logic [1:0] ab;
  logic [2:0] state, state_nxt;
  logic       enter_nxt, exit_nxt;
  logic       enter_q, exit_q;
  logic [3:0] tens, ones;
  logic       at_cap, at_zero;

  // Two-flop synchronizers for the asynchronous beam inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      a_meta <= 1'b0;
      a_sync <= 1'b0;
      b_meta <= 1'b0;
      b_sync <= 1'b0;
    end else begin
      a_meta <= bus.a;
      a_sync <= a_meta;
      b_meta <= bus.b;
      b_sync <= b_meta;
    end
  end

  assign ab = {a_sync, b_sync};

  // Next-state decode; a completion strobe is raised only on EN3/EX3 -> IDLE
  always_comb begin
    state_nxt = state;
    enter_nxt = 1'b0;
    exit_nxt  = 1'b0;
    case (state)
      IDLE: begin
        case (ab)
          2'b10:   state_nxt = EN1;
          2'b01:   state_nxt = EX1;
          2'b11:   state_nxt = WAIT_CLR;
          default: state_nxt = IDLE;
        endcase
      end
      EN1: begin
        case (ab)
          2'b11:   state_nxt = EN2;
          2'b00:   state_nxt = IDLE;
          2'b01:   state_nxt = WAIT_CLR;
          default: state_nxt = EN1;
        endcase
      end
      EN2: begin
        case (ab)
          2'b01:   state_nxt = EN3;
          2'b10:   state_nxt = EN1;
          2'b00:   state_nxt = WAIT_CLR;
          default: state_nxt = EN2;
        endcase
      end
      EN3: begin
        case (ab)
          2'b00: begin
            state_nxt = IDLE;
            enter_nxt = 1'b1;
          end
          2'b11:   state_nxt = EN2;
          2'b10:   state_nxt = WAIT_CLR;
          default: state_nxt = EN3;
        endcase
      end
      EX1: begin
        case (ab)
          2'b11:   state_nxt = EX2;
          2'b00:   state_nxt = IDLE;
          2'b10:   state_nxt = WAIT_CLR;
          default: state_nxt = EX1;
        endcase
      end
      EX2: begin
        case (ab)
          2'b10:   state_nxt = EX3;
          2'b01:   state_nxt = EX1;
          2'b00:   state_nxt = WAIT_CLR;
          default: state_nxt = EX2;
        endcase
      end
      EX3: begin
        case (ab)
          2'b00: begin
            state_nxt = IDLE;
            exit_nxt  = 1'b1;
          end
          2'b11:   state_nxt = EX2;
          2'b01:   state_nxt = WAIT_CLR;
          default: state_nxt = EX3;
        endcase
      end
      WAIT_CLR: begin
        if (ab == 2'b00) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered completion strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      enter_q <= enter_nxt;
      exit_q  <= exit_nxt;
    end
  end

  assign at_cap  = (tens == CAP_TENS) && (ones == CAP_ONES);
  assign at_zero = (tens == 4'd0) && (ones == 4'd0);

  // Saturating BCD occupancy count, updated the edge after a strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (enter_q && !at_cap) begin
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end else if (exit_q && !at_zero) begin
      if (ones == 4'd0) begin
        ones <= 4'd9;
        tens <= tens - 4'd1;
      end else begin
        ones <= ones - 4'd1;
      end
    end
  end

  assign bus.bcd   = {tens, ones};
  assign bus.enter = enter_q;
  assign bus.exit  = exit_q;
  assign bus.full  = at_cap;
  assign bus.empty = at_zero;
  assign bus.state = state;

endmodule

// File: tb/tb_parking_lot_counter.sv
// Bench for parking_lot_counter: directed gate scenarios followed by random
// car transactions, checked against an integer occupancy model.
module tb_parking_lot_counter;

  localparam int CAP = 25;
  localparam logic [7:0] S_IDLE = 8'd0;
  localparam logic [7:0] S_WAIT = 8'd7;
  localparam int N_KIND = 6;
  localparam int MAX_LEN = 6;

  logic clk = 1'b0;
  logic reset;

  parking_lot_if bus ();

  parking_lot_counter #(.CAPACITY(CAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int model_count = 0;
  int hold_n = 3;
  logic [7:0] exp_q[$];

  // transaction table: beam sequences {a,b}, each ending with 00
  logic [1:0] seq_tab [N_KIND][MAX_LEN];
  int         seq_len [N_KIND];
  int         kind_enter [N_KIND];
  int         kind_exit  [N_KIND];

  // pulse monitor
  int   enter_seen = 0;
  int   exit_seen = 0;
  int   proto_err = 0;
  logic prev_enter = 1'b0;
  logic prev_exit = 1'b0;

  always @(negedge clk) begin
    if (bus.enter) enter_seen++;
    if (bus.exit) exit_seen++;
    if (bus.enter && bus.exit) proto_err++;
    if (bus.enter && prev_enter) proto_err++;
    if (bus.exit && prev_exit) proto_err++;
    prev_enter = bus.enter;
    prev_exit = bus.exit;
  end

  function automatic logic [7:0] to_bcd(int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: set beams at a negedge and hold for n cycles
  task automatic hold(input logic [1:0] ab, input int n);
    {bus.a, bus.b} = ab;
    repeat (n) @(negedge clk);
  endtask

  task automatic model_apply(input int n_enter, input int n_exit);
    for (int i = 0; i < n_enter; i++) if (model_count < CAP) model_count++;
    for (int i = 0; i < n_exit; i++) if (model_count > 0) model_count--;
    exp_q.push_back(to_bcd(model_count));
  endtask

  task automatic check_after(input string tag, input int e0, input int x0,
                             input int exp_e, input int exp_x);
    logic [7:0] exp_bcd;
    exp_bcd = exp_q.pop_front();
    check({tag, " enter_pulses"}, 8'(enter_seen - e0), 8'(exp_e));
    check({tag, " exit_pulses"}, 8'(exit_seen - x0), 8'(exp_x));
    check({tag, " bcd"}, bus.bcd, exp_bcd);
    check({tag, " full"}, 8'(bus.full), 8'(exp_bcd == to_bcd(CAP)));
    check({tag, " empty"}, 8'(bus.empty), 8'(exp_bcd == 8'h00));
    check({tag, " state"}, 8'(bus.state), S_IDLE);
    check({tag, " strobe_protocol"}, 8'(proto_err), 8'd0);
  endtask

  task automatic run_txn(input string tag, input int kind);
    int e0, x0;
    e0 = enter_seen;
    x0 = exit_seen;
    for (int i = 0; i < seq_len[kind]; i++) hold(seq_tab[kind][i], hold_n);
    repeat (5) @(negedge clk);
    model_apply(kind_enter[kind], kind_exit[kind]);
    check_after(tag, e0, x0, kind_enter[kind], kind_exit[kind]);
  endtask

  initial begin
    int e0, x0, waited;
    bit found;

    seq_tab[0] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00}; seq_len[0] = 4;
    seq_tab[1] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00}; seq_len[1] = 4;
    seq_tab[2] = '{2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00}; seq_len[2] = 4;
    seq_tab[3] = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00}; seq_len[3] = 4;
    seq_tab[4] = '{2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00}; seq_len[4] = 3;
    seq_tab[5] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b00}; seq_len[5] = 6;
    kind_enter = '{1, 0, 0, 0, 0, 1};
    kind_exit  = '{0, 1, 0, 0, 0, 0};

    // reset
    reset = 1'b1;
    bus.a = 1'b0;
    bus.b = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset bcd", bus.bcd, 8'h00);
    check("reset empty", 8'(bus.empty), 8'd1);
    check("reset full", 8'(bus.full), 8'd0);
    check("reset enter", 8'(bus.enter), 8'd0);
    check("reset exit", 8'(bus.exit), 8'd0);
    check("reset state", 8'(bus.state), S_IDLE);

    // first entry with pulse latency and bcd follow-up timing
    e0 = enter_seen;
    x0 = exit_seen;
    hold(2'b00, 3);
    hold(2'b10, 3);
    hold(2'b11, 3);
    hold(2'b01, 3);
    {bus.a, bus.b} = 2'b00;
    found = 1'b0;
    waited = 0;
    while (!found && waited < 10) begin
      @(negedge clk);
      waited++;
      if (bus.enter) found = 1'b1;
    end
    check("entry pulse seen", 8'(found), 8'd1);
    check("entry pulse latency", 8'(waited), 8'd3);
    check("bcd during pulse", bus.bcd, 8'h00);
    @(negedge clk);
    check("bcd after pulse", bus.bcd, 8'h01);
    check("enter one cycle", 8'(bus.enter), 8'd0);
    repeat (5) @(negedge clk);
    model_apply(1, 0);
    check_after("first_entry", e0, x0, 1, 0);

    // directed scenarios
    run_txn("exit", 1);
    run_txn("entry_reverse", 2);
    run_txn("exit_reverse", 3);
    run_txn("glitch_11", 4);
    run_txn("exit_at_zero", 1);
    for (int i = 0; i < 9; i++) run_txn("entry_to_9", 0);
    run_txn("carry_10", 0);
    run_txn("borrow_09", 1);
    run_txn("entry_wobble", 5);

    // saturation from zero
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_count = 0;
    for (int i = 0; i < 26; i++) run_txn("sat_entry", 0);

    // reset in the middle of a traversal with both beams blocked
    e0 = enter_seen;
    x0 = exit_seen;
    hold(2'b10, 3);
    hold(2'b11, 3);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset bcd", bus.bcd, 8'h00);
    check("midreset state", 8'(bus.state), S_IDLE);
    check("midreset enter", 8'(bus.enter), 8'd0);
    reset = 1'b0;
    model_count = 0;
    repeat (5) @(negedge clk);
    check("post_reset wait_clr", 8'(bus.state), S_WAIT);
    hold(2'b01, 5);
    check("post_reset still wait", 8'(bus.state), S_WAIT);
    hold(2'b00, 5);
    model_apply(0, 0);
    check_after("post_reset", e0, x0, 0, 0);

    // random transactions
    for (int t = 0; t < 60; t++) begin
      hold_n = $urandom_range(3, 6);
      run_txn("random", $urandom_range(0, N_KIND - 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  // overall time bound
  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
